// File: rtl/idelay_loader.sv
// idelay_loader: captures scanner tap writes into a 16-entry shadow file and loads them one lane at a time.
// Optional readback verification is compiled in with IDELAY_LOADER_VERIFY_EN.
module idelay_loader #(
    parameter int settle_cycles = 4
) (
    input  logic        lb_clk,
    input  logic        rst_n,
    input  logic [3:0]  hw_addr,
    input  logic [4:0]  hw_data,
    input  logic        hw_strobe,
    output logic [15:0] idelay_ld,
    output logic [4:0]  idelay_cntvaluein,
    input  logic [79:0] idelay_cntvalueout,
    input  logic [3:0]  rb_addr,
    output logic [4:0]  rb_data,
    input  logic        mismatch_clear,
    output logic [15:0] mismatch_mask,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, CHECK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pending_q, pending_d;
    logic [4:0]  shadow_q [16];
    logic [4:0]  shadow_d [16];
    logic [15:0] ld_q, ld_d;
    logic [4:0]  cntval_q, cntval_d;
    logic [4:0]  rb_data_q, rb_data_d;
    logic        busy_q, busy_d;
    logic [15:0] mask_q, mask_d;
    logic [3:0]  low_idx_s;

    // Lowest-numbered pending lane; scanning downward leaves the lowest match last.
    always_comb begin
        low_idx_s = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx_s = 4'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Shadow file write port and registered readback.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (hw_strobe) begin
            shadow_d[hw_addr] = hw_data;
        end else begin
            shadow_d[hw_addr] = shadow_q[hw_addr];
        end
        rb_data_d = shadow_q[rb_addr];
    end

    // Sequencer next state, load pulse and pending bookkeeping.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ld_d      = 16'h0000;
        cntval_d  = cntval_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 16'h0000) begin
                    sel_d              = low_idx_s;
                    pending_d[low_idx_s] = 1'b0;
                    ld_d               = 16'h0001 << low_idx_s;
                    cntval_d           = shadow_q[low_idx_s];
                    state_d            = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                cnt_d   = 4'(settle_cycles);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q <= 4'd1) begin
`ifdef IDELAY_LOADER_VERIFY_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new strobe always wins over the IDLE clear of the same lane.
        if (hw_strobe) begin
            pending_d[hw_addr] = 1'b1;
        end else begin
            pending_d[hw_addr] = pending_d[hw_addr];
        end
        busy_d = (pending_d != 16'h0000) || (state_q != IDLE);
    end

`ifdef IDELAY_LOADER_VERIFY_EN
    // Sticky mismatch flags; a CHECK set overrides a same-cycle clear.
    always_comb begin
        mask_d = mask_q;
        if (mismatch_clear) begin
            mask_d = 16'h0000;
        end else begin
            mask_d = mask_q;
        end
        if ((state_q == CHECK) && (idelay_cntvalueout[int'(sel_q) * 5 +: 5] != cntval_q)) begin
            mask_d[sel_q] = 1'b1;
        end else begin
            mask_d[sel_q] = mask_d[sel_q];
        end
    end
`else
    assign mask_d = 16'h0000;
    wire unused_verify_s = ^{idelay_cntvalueout, mismatch_clear, mask_q};
`endif

    // State and output registers.
    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            cnt_q     <= 4'd0;
            pending_q <= 16'h0000;
            ld_q      <= 16'h0000;
            cntval_q  <= 5'd0;
            rb_data_q <= 5'd0;
            busy_q    <= 1'b0;
            mask_q    <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 5'd0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ld_q      <= ld_d;
            cntval_q  <= cntval_d;
            rb_data_q <= rb_data_d;
            busy_q    <= busy_d;
            mask_q    <= mask_d;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign idelay_ld         = ld_q;
    assign idelay_cntvaluein = cntval_q;
    assign rb_data           = rb_data_q;
    assign busy              = busy_q;
`ifdef IDELAY_LOADER_VERIFY_EN
    assign mismatch_mask     = mask_q;
`else
    assign mismatch_mask     = 16'h0000;
`endif

endmodule

// File: tb/tb_idelay_loader.sv
// Scoreboard bench for idelay_loader: a slot-level reference model predicts every load pulse, busy, rb_data and mismatch_mask.
module tb_idelay_loader;
    localparam int S = 4;
`ifdef IDELAY_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int T = S + (VERIFY ? 3 : 2);

    logic        lb_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  hw_addr = 4'd0;
    logic [4:0]  hw_data = 5'd0;
    logic        hw_strobe = 1'b0;
    logic [15:0] idelay_ld;
    logic [4:0]  idelay_cntvaluein;
    logic [79:0] idelay_cntvalueout = 80'd0;
    logic [3:0]  rb_addr = 4'd0;
    logic [4:0]  rb_data;
    logic        mismatch_clear = 1'b0;
    logic [15:0] mismatch_mask;
    logic        busy;

    idelay_loader #(.settle_cycles(S)) dut (
        .lb_clk(lb_clk), .rst_n(rst_n), .hw_addr(hw_addr), .hw_data(hw_data),
        .hw_strobe(hw_strobe), .idelay_ld(idelay_ld), .idelay_cntvaluein(idelay_cntvaluein),
        .idelay_cntvalueout(idelay_cntvalueout), .rb_addr(rb_addr), .rb_data(rb_data),
        .mismatch_clear(mismatch_clear), .mismatch_mask(mismatch_mask), .busy(busy)
    );

    always #5 lb_clk = ~lb_clk;

    typedef struct { int lane; int val; int cyc; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass = 0;
    bit corrupt = 1'b0;

    // reference model state
    int m_shadow [16];
    bit m_pending [16];
    int m_timer = 0;
    int m_cyc = 0;
    int m_rb = 0;
    bit m_busy = 1'b0;
    logic [15:0] m_mask = 16'h0;
    int cur_lane = 0;
    bit cur_bad = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: one lane is serviced per T-cycle slot, lowest pending first.
    initial begin
        for (int i = 0; i < 16; i++) begin m_shadow[i] = 0; m_pending[i] = 0; end
        forever begin
            @(posedge lb_clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 16; i++) begin m_shadow[i] = 0; m_pending[i] = 0; end
                m_timer = 0; m_cyc = 0; m_rb = 0; m_busy = 0; m_mask = 16'h0;
                exp_q.delete();
            end else begin
                bit was_active;
                bit any;
                m_rb = m_shadow[rb_addr];
                was_active = (m_timer > 0);
                if (VERIFY && mismatch_clear) m_mask = 16'h0;
                if (m_timer > 0) begin
                    if (VERIFY && m_timer == 1 && cur_bad) m_mask[cur_lane] = 1'b1;
                    m_timer--;
                end else begin
                    int pick;
                    pick = -1;
                    for (int i = 15; i >= 0; i--) if (m_pending[i]) pick = i;
                    if (pick >= 0) begin
                        exp_t e;
                        e.lane = pick; e.val = m_shadow[pick]; e.cyc = m_cyc + 1;
                        exp_q.push_back(e);
                        cur_lane = pick;
                        cur_bad = corrupt && (pick == 5) && (m_shadow[pick] != 11);
                        m_pending[pick] = 0;
                        m_timer = T - 1;
                    end
                end
                if (hw_strobe) begin
                    m_shadow[hw_addr] = hw_data;
                    m_pending[hw_addr] = 1;
                end
                any = 0;
                for (int i = 0; i < 16; i++) any |= m_pending[i];
                m_busy = any || was_active;
                m_cyc++;
            end
        end
    end

    // Monitor and primitive model: pulses are popped from the scoreboard, taps echo loads.
    initial begin
        logic [15:0] prev_ld;
        prev_ld = 16'h0;
        forever begin
            @(negedge lb_clk);
            if (rst_n) begin
                check("ld_shape", int'(((idelay_ld & (idelay_ld - 16'd1)) == 16'h0) &&
                      !((prev_ld != 16'h0) && (idelay_ld != 16'h0))), 1);
                if (idelay_ld != 16'h0) begin
                    if (exp_q.size() == 0) begin
                        check("ld_unexpected", int'(idelay_ld), 0);
                    end else begin
                        exp_t e;
                        int lane;
                        e = exp_q.pop_front();
                        lane = -1;
                        for (int i = 0; i < 16; i++) if (idelay_ld[i]) lane = i;
                        check("ld_lane", lane, e.lane);
                        check("ld_value", int'(idelay_cntvaluein), e.val);
                        check("ld_cycle", m_cyc, e.cyc);
                        if (lane >= 0)
                            idelay_cntvalueout[lane*5 +: 5] = (corrupt && lane == 5) ? 5'd11 : idelay_cntvaluein;
                    end
                end
                prev_ld = idelay_ld;
                check("busy", int'(busy), int'(m_busy));
                check("rb_data", int'(rb_data), m_rb);
                check("mismatch_mask", int'(mismatch_mask), int'(m_mask));
            end else begin
                prev_ld = 16'h0;
            end
        end
    end

    task automatic drive(input bit s, input int a, input int d, input int rb);
        @(negedge lb_clk);
        hw_strobe = s;
        hw_addr = 4'(a);
        hw_data = 5'(d);
        rb_addr = (rb < 0) ? 4'($urandom_range(15, 0)) : 4'(rb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, -1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld"}, int'(idelay_ld), 0);
        check({tag, "_cntvaluein"}, int'(idelay_cntvaluein), 0);
        check({tag, "_mask"}, int'(mismatch_mask), 0);
        check({tag, "_rb_data"}, int'(rb_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        bit found;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge lb_clk);
        rst_n = 1'b1;

        // single write, then read the shadow back
        drive(1'b1, 7, 30, -1);
        idle(T + 4);
        drive(1'b0, 0, 0, 7);
        @(posedge lb_clk); #1;
        check("rb_lane7", int'(rb_data), 30);

        // burst of 16 writes on consecutive cycles
        for (int k = 0; k < 16; k++) drive(1'b1, k, 2 * k, -1);
        idle(16 * T + 4);

        // coalescing behind a lane-0 load
        drive(1'b1, 0, 1, -1);
        drive(1'b1, 3, 5, -1);
        drive(1'b1, 3, 9, -1);
        drive(1'b1, 3, 12, -1);
        idle(3 * T);

        // rewrite during SETTLE
        drive(1'b1, 2, 10, -1);
        idle(3);
        drive(1'b1, 2, 20, -1);
        idle(3 * T);

        // corrupted readback on lane 5
        corrupt = 1'b1;
        drive(1'b1, 5, 17, -1);
        idle(T + 3);
        check("mask_lane5", int'(mismatch_mask), VERIFY ? 32'h20 : 0);
        drive(1'b1, 5, 17, -1);
        found = 1'b0;
        for (int i = 0; i < 4 * T && !found; i++) begin
            drive(1'b0, 0, 0, -1);
            if (m_timer == 1) begin
                mismatch_clear = 1'b1;
                found = 1'b1;
            end
        end
        check("clear_window_found", int'(found), 1);
        drive(1'b0, 0, 0, -1);
        mismatch_clear = 1'b0;
        idle(3);
        check("mask_set_wins", int'(mismatch_mask), VERIFY ? 32'h20 : 0);
        @(negedge lb_clk);
        mismatch_clear = 1'b1;
        @(negedge lb_clk);
        mismatch_clear = 1'b0;
        idle(2);
        check("mask_cleared", int'(mismatch_mask), 0);

        // randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3, 0) == 0), int'($urandom_range(15, 0)), int'($urandom_range(31, 0)), -1);
            mismatch_clear = ($urandom_range(7, 0) == 0);
        end
        drive(1'b0, 0, 0, -1);
        mismatch_clear = 1'b0;
        idle(17 * T);
        corrupt = 1'b0;

        // asynchronous reset in the middle of SETTLE with lanes pending
        drive(1'b1, 1, 21, -1);
        drive(1'b1, 4, 22, -1);
        drive(1'b1, 9, 23, -1);
        idle(3);
        @(negedge lb_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge lb_clk);
        rst_n = 1'b1;
        idle(4 * T);

        check("exp_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
